// File: rtl/pe_pkg.sv
// Shared constants and mode encoding for the multimode processing element.
package pe_pkg;

    localparam int unsigned PE_DATA_W = 16;
    localparam int unsigned PE_ACC_W  = 40;

    typedef enum logic [1:0] {
        MODE_MAC    = 2'b00,
        MODE_L1     = 2'b01,
        MODE_L2     = 2'b10,
        MODE_BYPASS = 2'b11
    } pe_mode_e;

endpackage

// File: rtl/pe_weight_buf.sv
// Double-buffered weight storage: one bank feeds the datapath while the
// other is loaded from the column daisy-chain; SWAP exchanges their roles.
module pe_weight_buf
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W = PE_DATA_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     W_EN,
    input  logic                     SWAP,
    input  logic signed [DATA_W-1:0] in_weight,
    output logic signed [DATA_W-1:0] active_w,
    output logic signed [DATA_W-1:0] shadow_w
);

    logic signed [DATA_W-1:0] bank0;
    logic signed [DATA_W-1:0] bank1;
    logic                     act_bank;

    // Bank writes always target the pre-swap shadow, so a simultaneous
    // write and swap makes the freshly written weight active next cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            bank0    <= '0;
            bank1    <= '0;
            act_bank <= 1'b0;
        end else begin
            if (W_EN) begin
                if (act_bank) bank0 <= in_weight;
                else          bank1 <= in_weight;
            end
            if (SWAP) act_bank <= ~act_bank;
        end
    end

    assign active_w = act_bank ? bank1 : bank0;
    assign shadow_w = act_bank ? bank0 : bank1;

endmodule

// File: rtl/pe_multimode.sv
// Systolic-array PE: two-stage MAC / L1 / L2 / bypass pipeline with a shared
// multiplier, saturating partial-sum accumulation and double-buffered weights.
module pe_multimode
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W = PE_DATA_W,
    parameter int unsigned ACC_W  = PE_ACC_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     EN,
    input  logic [1:0]               MODE,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] active_left,
    output logic signed [DATA_W-1:0] active_right,
    output logic                     act_valid_out,
    input  logic signed [ACC_W-1:0]  in_sum,
    output logic signed [ACC_W-1:0]  out_sum,
    output logic                     out_valid,
    input  logic                     W_EN,
    input  logic                     SWAP,
    input  logic signed [DATA_W-1:0] in_weight_above,
    output logic signed [DATA_W-1:0] out_weight_below,
    output logic                     sat_flag,
    input  logic                     clr_sat
);

    localparam int unsigned PROD_W = 2 * DATA_W + 2;

    if (ACC_W < PROD_W) begin : g_acc_w_check
        $error("pe_multimode: ACC_W must be at least 2*DATA_W+2");
    end

    logic signed [DATA_W-1:0] weight;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W:0]   mul_a;
    logic signed [DATA_W:0]   mul_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  diff_ext;
    logic signed [ACC_W-1:0]  term;
    pe_mode_e                 mode;

    logic signed [ACC_W-1:0]  term_q;
    logic signed [ACC_W-1:0]  sum_q;
    logic                     s1_valid;

    logic signed [ACC_W:0]    sum_ext;
    logic                     ovf;
    logic signed [ACC_W-1:0]  sat_val;
    logic                     sat_set;

    pe_weight_buf #(.DATA_W(DATA_W)) u_weight_buf (
        .CLK       (CLK),
        .RESET     (RESET),
        .W_EN      (W_EN),
        .SWAP      (SWAP),
        .in_weight (in_weight_above),
        .active_w  (weight),
        .shadow_w  (out_weight_below)
    );

    assign mode     = pe_mode_e'(MODE);
    assign diff     = {weight[DATA_W-1], weight} - {active_left[DATA_W-1], active_left};
    assign diff_ext = {{(ACC_W-DATA_W-1){diff[DATA_W]}}, diff};

    // Single shared multiplier: (w,a) for MAC, (d,d) for L2.
    always_comb begin
        mul_a = {weight[DATA_W-1], weight};
        mul_b = {active_left[DATA_W-1], active_left};
        if (mode == MODE_L2) begin
            mul_a = diff;
            mul_b = diff;
        end
        prod = PROD_W'(mul_a) * PROD_W'(mul_b);
    end

    // Select the per-mode term, sign-extended to the partial-sum width.
    always_comb begin
        term = '0;
        unique case (mode)
            MODE_MAC, MODE_L2: term = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            MODE_L1:           term = diff[DATA_W] ? -diff_ext : diff_ext;
            MODE_BYPASS:       term = '0;
            default:           term = '0;
        endcase
    end

    // Stage 1 and the east-bound activation forward; mode is captured via term.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            term_q        <= '0;
            sum_q         <= '0;
            s1_valid      <= 1'b0;
            active_right  <= '0;
            act_valid_out <= 1'b0;
        end else if (EN) begin
            s1_valid      <= in_valid;
            active_right  <= active_left;
            act_valid_out <= in_valid;
            if (in_valid) begin
                term_q <= term;
                sum_q  <= in_sum;
            end
        end
    end

    assign sum_ext = {term_q[ACC_W-1], term_q} + {sum_q[ACC_W-1], sum_q};
    assign ovf     = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    assign sat_val = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    assign sat_set = EN & s1_valid & ovf;

    // Stage 2: saturating accumulate; bubbles leave out_sum untouched.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else if (EN) begin
            out_valid <= s1_valid;
            if (s1_valid) out_sum <= ovf ? sat_val : sum_ext[ACC_W-1:0];
        end
    end

    // Sticky saturation flag; a new saturation wins over a same-cycle clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)       sat_flag <= 1'b0;
        else if (sat_set) sat_flag <= 1'b1;
        else if (clr_sat) sat_flag <= 1'b0;
    end

endmodule

// File: tb/tb_pe_multimode.sv
// Scoreboard bench for pe_multimode: driver pushes reference results, a
// monitor pops them whenever an enabled edge presents out_valid.
module tb_pe_multimode;

    localparam int DW = 8;
    localparam int AW = 20;
    localparam longint SUM_MAX = (longint'(1) << (AW - 1)) - 1;
    localparam longint SUM_MIN = -(longint'(1) << (AW - 1));

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic                 EN;
    logic [1:0]           MODE;
    logic                 in_valid;
    logic signed [DW-1:0] active_left;
    logic signed [DW-1:0] active_right;
    logic                 act_valid_out;
    logic signed [AW-1:0] in_sum;
    logic signed [AW-1:0] out_sum;
    logic                 out_valid;
    logic                 W_EN;
    logic                 SWAP;
    logic signed [DW-1:0] in_weight_above;
    logic signed [DW-1:0] out_weight_below;
    logic                 sat_flag;
    logic                 clr_sat;

    always #5 CLK = ~CLK;

    pe_multimode #(.DATA_W(DW), .ACC_W(AW)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .EN               (EN),
        .MODE             (MODE),
        .in_valid         (in_valid),
        .active_left      (active_left),
        .active_right     (active_right),
        .act_valid_out    (act_valid_out),
        .in_sum           (in_sum),
        .out_sum          (out_sum),
        .out_valid        (out_valid),
        .W_EN             (W_EN),
        .SWAP             (SWAP),
        .in_weight_above  (in_weight_above),
        .out_weight_below (out_weight_below),
        .sat_flag         (sat_flag),
        .clr_sat          (clr_sat)
    );

    int checks   = 0;
    int failures = 0;

    logic signed [AW-1:0] exp_q[$];
    longint               mw[2];
    int                   mact;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference result straight from the operation definitions.
    function automatic longint ref_result(input int mode, input longint w, input longint a,
                                          input longint s);
        longint t;
        longint r;
        case (mode)
            0:       t = w * a;
            1:       t = (w > a) ? (w - a) : (a - w);
            2:       t = (w - a) * (w - a);
            default: t = 0;
        endcase
        r = t + s;
        if (r > SUM_MAX) r = SUM_MAX;
        if (r < SUM_MIN) r = SUM_MIN;
        return r;
    endfunction

    // One clock: record expected result, update weight model, advance to negedge.
    task automatic tick();
        longint r;
        if (RESET && EN && in_valid) begin
            r = ref_result(int'(MODE), mw[mact], longint'(active_left), longint'(in_sum));
            exp_q.push_back(r[AW-1:0]);
        end
        if (RESET) begin
            if (W_EN) mw[1-mact] = longint'(in_weight_above);
            if (SWAP) mact = 1 - mact;
        end
        @(posedge CLK);
        @(negedge CLK);
        check("shadow_weight", longint'(out_weight_below), mw[1-mact]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        W_EN     = 1'b0;
        SWAP     = 1'b0;
        clr_sat  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic [1:0] m, input longint a, input longint s);
        MODE        = m;
        active_left = a[DW-1:0];
        in_sum      = s[AW-1:0];
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic load(input longint w);
        W_EN            = 1'b1;
        SWAP            = 1'b1;
        in_weight_above = w[DW-1:0];
        tick();
        W_EN            = 1'b0;
        SWAP            = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_active_right"}, longint'(active_right), 0);
        check({tag, "_act_valid_out"}, longint'(act_valid_out), 0);
        check({tag, "_out_sum"}, longint'(out_sum), 0);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_sat_flag"}, longint'(sat_flag), 0);
        check({tag, "_weight_below"}, longint'(out_weight_below), 0);
    endtask

    // Monitor: compares forwarded activation and pops results on enabled edges.
    initial begin : monitor
        logic                 e;
        logic                 iv;
        logic signed [DW-1:0] al;
        logic signed [AW-1:0] req;
        forever begin
            @(posedge CLK);
            e  = EN && RESET;
            iv = in_valid;
            al = active_left;
            #1;
            if (e) begin
                check("active_right", longint'(active_right), longint'(al));
                check("act_valid_out", longint'(act_valid_out), longint'(iv));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_out_valid: got out_sum %0d, expected no result", out_sum);
                    end else begin
                        req = exp_q.pop_front();
                        check("out_sum", longint'(out_sum), longint'(req));
                    end
                end
            end
        end
    end

    initial begin : driver
        logic signed [DW-1:0] rw;
        mw[0] = 0; mw[1] = 0; mact = 0;
        RESET = 1'b0; EN = 1'b1; MODE = 2'b00; in_valid = 1'b0; active_left = '0;
        in_sum = '0; W_EN = 1'b0; SWAP = 1'b0; in_weight_above = '0; clr_sat = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_all_zero("reset");
        RESET = 1'b1;
        idle(1);

        // Load 3 into shadow, swap it active, then MAC with latency check.
        W_EN = 1'b1; in_weight_above = 8'sd3; tick();
        W_EN = 1'b0; SWAP = 1'b1; tick();
        SWAP = 1'b0;
        issue(2'b00, -5, 100);
        check("mac_latency_1", longint'(out_valid), 0);
        idle(1);
        check("mac_latency_2", longint'(out_valid), 1);
        check("mac_result", longint'(out_sum), 85);

        // Write and swap together: new weight active, old active now shadow.
        load(6);
        check("swap_old_active", longint'(out_weight_below), 3);
        issue(2'b00, 2, 0);
        idle(1);
        check("swap_mac", longint'(out_sum), 12);

        load(10);
        issue(2'b01, -20, 7);
        idle(1);
        check("l1_result", longint'(out_sum), 37);
        load(-4);
        issue(2'b10, 3, 1);
        idle(1);
        check("l2_result", longint'(out_sum), 50);
        issue(2'b11, 55, 9);
        idle(1);
        check("bypass_result", longint'(out_sum), 9);

        // Positive saturation and sticky flag.
        load(127);
        issue(2'b00, 127, 524000);
        idle(1);
        check("sat_pos_sum", longint'(out_sum), 524287);
        check("sat_pos_flag", longint'(sat_flag), 1);
        idle(3);
        check("sat_sticky", longint'(sat_flag), 1);
        clr_sat = 1'b1; tick(); clr_sat = 1'b0;
        check("sat_cleared", longint'(sat_flag), 0);

        // Negative saturation with clr_sat on the same edge: set wins.
        load(-128);
        issue(2'b00, 1, -524288);
        clr_sat = 1'b1; tick(); clr_sat = 1'b0;
        check("sat_neg_sum", longint'(out_sum), -524288);
        check("sat_set_wins", longint'(sat_flag), 1);
        clr_sat = 1'b1; tick(); clr_sat = 1'b0;

        // Stream of four with a three-cycle stall in the middle.
        load(7);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                EN = 1'b0;
                in_valid = 1'b1;
                active_left = 8'sd99;
                for (int k = 0; k < 3; k++) tick();
                EN = 1'b1;
            end
            issue(2'(i), longint'(i * 11 - 20), longint'(i * 1000 - 1500));
        end
        idle(4);
        check("stall_drain", longint'(exp_q.size()), 0);

        // Reset with two results in flight.
        issue(2'b00, 4, 40);
        issue(2'b01, -4, 41);
        RESET = 1'b0;
        exp_q.delete();
        mw[0] = 0; mw[1] = 0; mact = 0;
        #1;
        check_all_zero("midreset");
        tick();
        tick();
        RESET = 1'b1;
        idle(5);
        check("post_reset_valid", longint'(out_valid), 0);
        check("post_reset_sum", longint'(out_sum), 0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            EN          = ($urandom_range(0, 9) != 0);
            MODE        = 2'($urandom);
            in_valid    = ($urandom_range(0, 3) != 0);
            active_left = DW'($urandom);
            in_sum      = AW'($urandom);
            rw          = DW'($urandom);
            in_weight_above = rw;
            W_EN        = ($urandom_range(0, 3) == 0);
            SWAP        = ($urandom_range(0, 5) == 0);
            clr_sat     = ($urandom_range(0, 7) == 0);
            tick();
        end
        EN = 1'b1;
        idle(4);
        check("random_drain", longint'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
